// File: rtl/tate_result_serializer_if.sv
// Word-stream handshake between the result serializer and a narrow host/bus port.
// The master drives data, valid and last; the slave returns ready.
interface tate_result_serializer_if #(
    parameter int DW = 32
);
    logic          tx_valid;
    logic          tx_ready;
    logic [DW-1:0] tx_data;
    logic          tx_last;

    modport master (output tx_valid, output tx_data, output tx_last, input tx_ready);
    modport slave  (input tx_valid, input tx_data, input tx_last, output tx_ready);
endinterface

// File: rtl/tate_result_serializer.sv
// Captures the 1164-bit tate_pairing result on a done rise and streams it LSB word first, 1 clk to first valid;
// a stalled word holds while tx_ready is low. TATE_SER_CHECKSUM_EN appends an XOR checksum word.
module tate_result_serializer #(
    parameter int DW = 32
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             done_in,
    input  logic [1163:0]                    res_in,
    tate_result_serializer_if.master         tx,
    output logic                             busy,
    output logic                             overrun,
    input  logic                             clr_overrun
);
    localparam int RW = 1164;
    localparam int NW = (RW + DW - 1) / DW;
    localparam int IW = (NW > 1) ? $clog2(NW) : 1;
    localparam int PW = NW * DW;
    localparam int OW = $clog2(PW);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SEND = 2'd1;
`ifdef TATE_SER_CHECKSUM_EN
    localparam logic [1:0] S_CSUM = 2'd2;
`endif

    logic [1:0]    state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          done_d_q;
    logic          overrun_q, overrun_d;
    logic [RW-1:0] shadow_q, shadow_d;
`ifdef TATE_SER_CHECKSUM_EN
    logic [DW-1:0] csum_q, csum_d;
`endif

    logic [PW-1:0] shadow_pad;
    logic [OW-1:0] bit_off;
    logic [DW-1:0] word;
    logic          rise;
    logic          fire;
    logic          last_idx;

    assign rise       = done_in & ~done_d_q;
    // Zero-extending the shadow makes the bits above the result read as 0 in the final word.
    assign shadow_pad = PW'(shadow_q);
    assign bit_off    = OW'(idx_q) * OW'(DW);
    assign word       = shadow_pad[bit_off +: DW];
    assign last_idx   = (idx_q == IW'(NW - 1));
    assign fire       = tx.tx_valid & tx.tx_ready;

    assign tx.tx_valid = (state_q != S_IDLE);
    assign busy        = (state_q != S_IDLE);
    assign overrun     = overrun_q;

    always_comb begin
        tx.tx_data = '0;
        tx.tx_last = 1'b0;
        if (state_q == S_SEND) begin
            tx.tx_data = word;
`ifndef TATE_SER_CHECKSUM_EN
            tx.tx_last = last_idx;
`endif
        end
`ifdef TATE_SER_CHECKSUM_EN
        if (state_q == S_CSUM) begin
            tx.tx_data = csum_q;
            tx.tx_last = 1'b1;
        end
`endif
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        shadow_d  = shadow_q;
        overrun_d = overrun_q;
`ifdef TATE_SER_CHECKSUM_EN
        csum_d    = csum_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (rise) begin
                    shadow_d = res_in;
                    idx_d    = '0;
                    state_d  = S_SEND;
`ifdef TATE_SER_CHECKSUM_EN
                    csum_d   = '0;
`endif
                end
            end
            S_SEND: begin
                if (fire) begin
`ifdef TATE_SER_CHECKSUM_EN
                    csum_d = csum_q ^ word;
`endif
                    if (last_idx) begin
                        idx_d = '0;
`ifdef TATE_SER_CHECKSUM_EN
                        state_d = S_CSUM;
`else
                        state_d = S_IDLE;
`endif
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
`ifdef TATE_SER_CHECKSUM_EN
            S_CSUM: begin
                if (fire) state_d = S_IDLE;
            end
`endif
            default: state_d = S_IDLE;
        endcase
        // A rise while a frame is in flight (including its final edge) is dropped; set beats clear.
        if (clr_overrun) overrun_d = 1'b0;
        if (rise && (state_q != S_IDLE)) overrun_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            done_d_q  <= 1'b0;
            overrun_q <= 1'b0;
`ifdef TATE_SER_CHECKSUM_EN
            csum_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            done_d_q  <= done_in;
            overrun_q <= overrun_d;
`ifdef TATE_SER_CHECKSUM_EN
            csum_q    <= csum_d;
`endif
        end
    end

    // Shadow contents are only observable in SEND, so they need no reset.
    always_ff @(posedge clk) begin
        shadow_q <= shadow_d;
    end
endmodule

// File: tb/tb_tate_result_serializer.sv
// Randomized self-checking bench for tate_result_serializer against a word-list reference model.
module tb_tate_result_serializer;
    localparam int DW = 32;
    localparam int NW = 37;
`ifdef TATE_SER_CHECKSUM_EN
    localparam int FN = NW + 1;
`else
    localparam int FN = NW;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          done_in;
    logic [1163:0] res_in;
    logic          busy;
    logic          overrun;
    logic          clr_overrun;
    logic          rand_rdy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_xfer_cyc = 0;

    logic [DW-1:0] rx_w[$];
    logic          rx_l[$];
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_dat;
    logic          prev_last;

    tate_result_serializer_if #(.DW(DW)) tx_if ();

    tate_result_serializer #(.DW(DW)) dut (
        .clk         (clk),
        .reset       (rst_n),
        .done_in     (done_in),
        .res_in      (res_in),
        .tx          (tx_if),
        .busy        (busy),
        .overrun     (overrun),
        .clr_overrun (clr_overrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Monitor: a word is recorded at the negedge before the edge that transfers it.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_vld", 64'(tx_if.tx_valid), 64'd1);
                check("stall_dat", 64'(tx_if.tx_data), 64'(prev_dat));
                check("stall_last", 64'(tx_if.tx_last), 64'(prev_last));
            end
            if (tx_if.tx_valid && tx_if.tx_ready) begin
                rx_w.push_back(tx_if.tx_data);
                rx_l.push_back(tx_if.tx_last);
                last_xfer_cyc = cyc + 1;
            end
            prev_stall = tx_if.tx_valid && !tx_if.tx_ready;
            prev_dat   = tx_if.tx_data;
            prev_last  = tx_if.tx_last;
        end
    end

    function automatic logic [63:0] rxw(input int i);
        if (i < rx_w.size()) return 64'(rx_w[i]);
        return 'x;
    endfunction

    function automatic logic [63:0] rxl(input int i);
        if (i < rx_l.size()) return 64'(rx_l[i]);
        return 'x;
    endfunction

    function automatic logic [1163:0] rand_vec();
        logic [1163:0] v = '0;
        for (int i = 0; i < 37; i++) v = (v << 32) | 1164'($urandom);
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        if (rand_rdy) tx_if.tx_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic clear_rx();
        rx_w.delete();
        rx_l.delete();
    endtask

    task automatic start_frame(input logic [1163:0] v);
        res_in  = v;
        done_in = 1'b1;
        step();
        done_in = 1'b0;
        res_in  = rand_vec();
    endtask

    task automatic wait_words(input int n, input string tag);
        int k = 0;
        while (rx_w.size() < n && k < 3000) begin
            step();
            k++;
        end
        check({tag, "_reach"}, 64'(rx_w.size() >= n), 64'd1);
    endtask

    task automatic wait_idle(input string tag, output int fall);
        int k = 0;
        do begin
            step();
            k++;
        end while (busy && k < 3000);
        check({tag, "_idle"}, 64'(busy), 64'd0);
        fall = cyc;
    endtask

    // Reference frame: NW words cut from the result by shifting, LSB word first, plus optional XOR word.
    task automatic check_frame(input logic [1163:0] v, input int base, input string tag);
        logic [DW-1:0] w;
        logic [DW-1:0] x = '0;
        for (int i = 0; i < FN; i++) begin
            if (i < NW) begin
                w = DW'(v >> (i * DW));
                x = x ^ w;
            end else begin
                w = x;
            end
            check($sformatf("%s_w%0d", tag, i), rxw(base + i), 64'(w));
            check($sformatf("%s_l%0d", tag, i), rxl(base + i), 64'(i == FN - 1));
        end
    endtask

    task automatic clr_pulse(input string tag);
        clr_overrun = 1'b1;
        step();
        clr_overrun = 1'b0;
        check(tag, 64'(overrun), 64'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        logic [1163:0] va, vb, vc, vd;
        int fall, n_at;
        rst_n = 1'b0; done_in = 1'b0; res_in = '0; clr_overrun = 1'b0;
        rand_rdy = 1'b0; tx_if.tx_ready = 1'b1;
        #3;
        check("rst_vld", 64'(tx_if.tx_valid), 64'd0);
        check("rst_last", 64'(tx_if.tx_last), 64'd0);
        check("rst_dat", 64'(tx_if.tx_data), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_ovr", 64'(overrun), 64'd0);
        repeat (3) step();
        rst_n = 1'b1;
        step();

        // Basic frame with ready tied high
        clear_rx();
        va = rand_vec();
        va[63:0] = 64'h2260a05a_8241055a;
        start_frame(va);
        check("lat_vld", 64'(tx_if.tx_valid), 64'd1);
        check("lat_busy", 64'(busy), 64'd1);
        wait_idle("basic", fall);
        check("basic_n", 64'(rx_w.size()), 64'(FN));
        check("basic_w0", rxw(0), 64'h8241055a);
        check("basic_w1", rxw(1), 64'h2260a05a);
        check("basic_w36", rxw(36), {52'h0, va[1163:1152]});
        check("basic_busyfall", 64'(fall), 64'(last_xfer_cyc));
        check_frame(va, 0, "basic");

        // Random backpressure
        clear_rx();
        rand_rdy = 1'b1;
        vb = rand_vec();
        start_frame(vb);
        wait_idle("bp", fall);
        rand_rdy = 1'b0; tx_if.tx_ready = 1'b1;
        check("bp_n", 64'(rx_w.size()), 64'(FN));
        check_frame(vb, 0, "bp");

        // All-zero result
        clear_rx();
        start_frame('0);
        wait_idle("zero", fall);
        check("zero_n", 64'(rx_w.size()), 64'(FN));
        check_frame('0, 0, "zero");

        // Level done: two rises give exactly two frames
        clear_rx();
        vc = rand_vec();
        res_in = vc; done_in = 1'b1;
        repeat (100) step();
        done_in = 1'b0;
        repeat (5) step();
        vd = rand_vec();
        res_in = vd; done_in = 1'b1;
        repeat (100) step();
        done_in = 1'b0;
        step();
        check("lvl_n", 64'(rx_w.size()), 64'(2 * FN));
        check("lvl_ovr", 64'(overrun), 64'd0);
        check("lvl_busy", 64'(busy), 64'd0);
        check_frame(vc, 0, "lvl0");
        check_frame(vd, FN, "lvl1");

        // Overrun at word 10
        clear_rx();
        va = rand_vec();
        start_frame(va);
        wait_words(10, "ovr");
        res_in = rand_vec(); done_in = 1'b1;
        step();
        done_in = 1'b0;
        check("ovr_set", 64'(overrun), 64'd1);
        wait_idle("ovr", fall);
        repeat (50) step();
        check("ovr_n", 64'(rx_w.size()), 64'(FN));
        check_frame(va, 0, "ovr");
        clr_pulse("ovr_clr");

        // Set and clear on the same edge: set wins
        clear_rx();
        vb = rand_vec();
        start_frame(vb);
        wait_words(5, "setclr");
        done_in = 1'b1; clr_overrun = 1'b1;
        step();
        done_in = 1'b0; clr_overrun = 1'b0;
        check("setclr_ovr", 64'(overrun), 64'd1);
        wait_idle("setclr", fall);
        check("setclr_n", 64'(rx_w.size()), 64'(FN));
        check_frame(vb, 0, "setclr");
        clr_pulse("setclr_clr");

        // Rise on the final-transfer edge is dropped
        clear_rx();
        vc = rand_vec();
        start_frame(vc);
        wait_words(FN - 1, "fin");
        done_in = 1'b1; res_in = rand_vec();
        step();
        done_in = 1'b0;
        check("fin_ovr", 64'(overrun), 64'd1);
        repeat (60) step();
        check("fin_n", 64'(rx_w.size()), 64'(FN));
        check("fin_busy", 64'(busy), 64'd0);
        check_frame(vc, 0, "fin");
        clr_pulse("fin_clr");

        // Reset mid-frame
        clear_rx();
        vd = rand_vec();
        start_frame(vd);
        wait_words(20, "mrst");
        rst_n = 1'b0;
        #1;
        check("mrst_vld", 64'(tx_if.tx_valid), 64'd0);
        check("mrst_busy", 64'(busy), 64'd0);
        n_at = rx_w.size();
        repeat (3) step();
        rst_n = 1'b1;
        repeat (20) step();
        check("mrst_tail", 64'(rx_w.size()), 64'(n_at));
        check("mrst_vld2", 64'(tx_if.tx_valid), 64'd0);
        clear_rx();
        va = rand_vec();
        start_frame(va);
        wait_idle("mrst2", fall);
        check("mrst2_n", 64'(rx_w.size()), 64'(FN));
        check_frame(va, 0, "mrst2");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/tate_result_serializer.md
Name: tate_result_serializer

Overview:
- Sits downstream of tate_pairing and reads its wide GF(3^m)^6 result.
- Captures `out` on the rising edge of `done` and streams it as DW-bit words over a valid/ready interface toward a narrow host/bus port.
- Provides the readback path for the pairing core, whose only result port is a 1164-bit bus.

Parameters:
- DW, 32, output word width in bits; legal range 8..64.
- Derived localparam NW = ceil((`W6`+1)/DW) = 37 at DW=32; not overridable.

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- reset  input  1  asynchronous, active-low reset
- done_in  input  1  done level from tate_pairing
- res_in  input  `W6`+1 (1164)  result bus from tate_pairing; inc.v defines `WIDTH`=193, `W6`=1163
- tx_ready  input  1  downstream accepts the word
- tx_valid  output  1  tx_data is valid
- tx_data  output  DW  current word
- tx_last  output  1  final word of the frame
- busy  output  1  frame capture or transmission in progress
- overrun  output  1  sticky flag: a result was dropped
- clr_overrun  input  1  synchronous clear of overrun

Behaviour:
- Reset (reset low, asynchronous):
  - outputs tx_valid, tx_last, busy and overrun go to 0; tx_data goes to 0.
  - internal state: FSM goes to IDLE, word index goes to 0, done_d goes to 0, checksum accumulator goes to 0.
- Edge detect: done_d <= done_in each cycle; rise = done_in & ~done_d. A level-high `done` gives exactly one capture.
- IDLE:
  - On rise, latch res_in into the 1164-bit shadow register, set idx=0, go to SEND.
  - tx_valid is 1 on the cycle after the capturing edge. Latency from the done rising edge to first valid is 1 clk.
- SEND:
  - tx_data = shadow[idx*DW +: DW]; LSB word first.
  - Bits above bit 1163 in the final word read as 0. At DW=32 the final word is {20'h0, shadow[1163:1152]}.
  - tx_valid = 1. A word transfers on any edge where tx_valid & tx_ready.
  - On transfer with idx < NW-1: idx++.
  - On transfer with idx = NW-1: go to IDLE, or to CSUM when CHECKSUM is enabled.
  - tx_last = 1 only while idx = NW-1, and only if CHECKSUM is disabled.
- Stall: while tx_valid & ~tx_ready, tx_data and tx_last hold stable and idx holds.
- busy = 1 in SEND and CSUM, 0 in IDLE.
- Rise while not IDLE: the new result is discarded, the current frame continues unaffected, and overrun is set.
- Rise on the same edge the final word transfers: treated as not IDLE, so the result is dropped and overrun is set.
- overrun precedence: a set and clr_overrun on the same cycle leave overrun set.
- Reset mid-frame: the frame is abandoned immediately. No partial tail is sent after release.
- The core must hold res_in stable at capture; the serializer does not read res_in after the capture edge.

Optional Feature:
- Macro: TATE_SER_CHECKSUM_EN.
- Defined:
  - A DW-bit accumulator XORs every transferred data word; it is cleared at capture.
  - After the final data word the FSM enters CSUM and presents the XOR of all NW data words with tx_last=1, so one extra word is sent.
  - The frame is NW+1 = 38 words at DW=32. CSUM obeys the same stall rules and then returns to IDLE.
- Undefined: no accumulator and no CSUM state. The frame is NW words, with tx_last on word NW-1.

Test Plan:
- Basic frame, tx_ready tied 1, res_in = wish vector {148a60…205, 520094…609, a48404…695, 21905…868, 5565…558, a6298884…055a}, one-cycle done pulse:
  - word0 = 32'h8241055a and word1 = 32'h2260a05a.
  - Word 36 = {20'h0, wish[1163:1152]} with tx_last=1.
  - Exactly 37 transfers, and busy drops the cycle after the last transfer.
- Backpressure: tx_ready toggles with a pseudo-random pattern (≈50%) → words and order match the baseline, tx_data and tx_last stay stable on every stalled cycle, and no word is duplicated or skipped.
- Level done: done_in held high for 100 cycles, then low, then high again → exactly two frames; each frame is captured on its rising edge only.
- Overrun:
  - A second done rise is issued at word 10 with different res_in → the first frame completes intact, overrun=1, and no second frame is sent.
  - clr_overrun pulse → overrun=0 on the next cycle.
- Reset mid-frame: reset asserted at word 20 → tx_valid=0 and busy=0 immediately. After release with no new done, tx_valid stays 0; a new done then starts a fresh frame at word0.
- Checksum build (TATE_SER_CHECKSUM_EN): all-zero res_in gives 38 words with last word 0. With the wish vector, word 37 = XOR of words 0..36, and tx_last is only on word 37.
